nubus_slot_bridge: RTL and testbench
====================================

NUBUS_SLOT_BRIDGE -- requirements
Module: nubus_slot_bridge

Interface
REQ-001 SHALL provide parameter SLOT_ID, default 4'h9, the NuBus slot number placed in slot_addr[27:24].
REQ-002 SHALL provide parameter CPU_WIN, default 4'h6, the value of cpu_addr[23:20] that selects the 1 MB CPU window.
REQ-003 SHALL provide parameter TIMEOUT, default 255, the maximum number of cycles spent waiting for slot_ack_n.
REQ-004 clk  in  1  the single clock; every register in the block uses its rising edge.
REQ-005 reset_n  in  1  reset, synchronous and active-low.
REQ-006 cpu_addr  in  24  68000 address; bit 0 is implied 0.
REQ-007 cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw_n  in  1 each  68000 strobes and direction; strobes active-low, rw_n 1=read.
REQ-008 cpu_data_in  in  16  CPU write data.
REQ-009 cpu_data_out  out  16  read data returned to the CPU.
REQ-010 cpu_dtack_n, cpu_berr_n  out  1 each  CPU handshakes, active-low.
REQ-011 slot_addr  out  32  slot address; slot_data_out  out  16  write data.
REQ-012 slot_uds_lds  out  2  {uds,lds}, active-high; slot_rw_n  out  1; slot_select  out  1.
REQ-013 slot_ack_n  in  1  slot DTACK, active-low; slot_data_in  in  16  slot read data.

Function
REQ-014 Hit: cpu_as_n=0, at least one of uds_n/lds_n =0, and cpu_addr[23:20]==CPU_WIN, sampled in IDLE.
REQ-015 Offset remap, with off=cpu_addr[19:0]:
- off<0x80000 -> low24={4'h0,off}.
- 0x80000..0xBFFFF -> low24={8'h08,off[15:0]}.
- 0xC0000..0xFFFFF -> low24={4'hF,2'b00,off[17:0]}.
REQ-016 slot_addr SHALL equal {4'hF,SLOT_ID,low24}.
REQ-017 States: IDLE, REQ, HOLD, ERR, RELEASE.
REQ-018 IDLE on hit: capture slot_addr, slot_rw_n=cpu_rw_n, slot_uds_lds={~uds_n,~lds_n} and slot_data_out=cpu_data_in; assert slot_select on the next edge; go to REQ.
REQ-019 REQ, counter below TIMEOUT and slot_ack_n=1: hold every slot output stable and increment the 8-bit wait counter.
REQ-020 REQ, slot_ack_n=0: deassert slot_select; latch slot_data_in into cpu_data_out when reading (unchanged when writing); drive cpu_dtack_n=0; go to HOLD.
REQ-021 REQ, counter==TIMEOUT with no ack: deassert slot_select; drive cpu_berr_n=0; go to ERR.
REQ-022 HOLD and ERR: keep dtack_n or berr_n low until cpu_as_n=1 is sampled, then release it on that edge and go to RELEASE.
REQ-023 RELEASE: go to IDLE only when slot_ack_n=1 and cpu_as_n=1, so one CPU cycle never starts two slot transactions.
REQ-024 cpu_as_n=1 sampled in REQ (abort): deassert slot_select; assert neither dtack nor berr; go to RELEASE.
REQ-025 Abort and ack in the same cycle: the abort wins; no dtack is asserted.
REQ-026 Latency: slot_select rises 1 cycle after the hit is sampled; cpu_dtack_n falls 1 cycle after slot_ack_n=0 is sampled.
REQ-027 A non-hit cycle SHALL leave every output at its idle value.
REQ-028 The wait counter SHALL clear on entry to REQ and SHALL never wrap.

Reset
REQ-029 While reset_n=0 at an edge: state=IDLE, slot_select=0, cpu_dtack_n=1, cpu_berr_n=1, cpu_data_out=0, slot_addr=0, slot_data_out=0, slot_uds_lds=0, slot_rw_n=1, counter=0.
REQ-030 A reset asserted mid-transaction SHALL force these values on that edge regardless of the CPU strobes.

Verification
REQ-031 Word read at cpu_addr 0x600010 with ack after 1 cycle and slot_data_in=0xBEEF -> slot_addr=0xF9000010, slot_uds_lds=2'b11; cpu_data_out=0xBEEF with dtack_n=0 until AS rises.
REQ-032 Upper-byte write of 0xA500 at 0x680000 -> slot_addr=0xF9080000, slot_uds_lds=2'b10, slot_rw_n=0, slot_data_out=0xA500.
REQ-033 ROM read at 0x6C0004 -> slot_addr=0xF9F00004.
REQ-034 Hit with slot_ack_n held at 1 -> cpu_berr_n=0 exactly TIMEOUT+1 cycles after select rises; slot_select=0; dtack_n stays 1.
REQ-035 AS released in REQ, once on its own and once in the same cycle as an ack -> no dtack or berr; no new select until slot_ack_n=1.
REQ-036 reset_n=0 during HOLD -> all outputs at reset values on the next edge; the next hit proceeds normally.

Source files
------------

// File: rtl/nubus_slot_bridge.sv
// Bridges 68000 bus cycles in a 1 MB CPU window onto a NuBus slot transaction,
// remapping the window offset and returning DTACK or BERR to the CPU.
module nubus_slot_bridge #(
    parameter logic [3:0]  SLOT_ID = 4'h9,
    parameter logic [3:0]  CPU_WIN = 4'h6,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] cpu_addr,
    input  logic        cpu_as_n,
    input  logic        cpu_uds_n,
    input  logic        cpu_lds_n,
    input  logic        cpu_rw_n,
    input  logic [15:0] cpu_data_in,
    output logic [15:0] cpu_data_out,
    output logic        cpu_dtack_n,
    output logic        cpu_berr_n,
    output logic [31:0] slot_addr,
    output logic [15:0] slot_data_out,
    output logic [1:0]  slot_uds_lds,
    output logic        slot_rw_n,
    output logic        slot_select,
    input  logic        slot_ack_n,
    input  logic [15:0] slot_data_in,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_HOLD    = 3'd2,
        S_ERR     = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       hit;

    function automatic logic [23:0] remap_offset(input logic [19:0] off);
        logic [23:0] low;
        if (!off[19])
            low = {4'h0, off};
        else if (!off[18])
            low = {8'h08, off[15:0]};
        else
            low = {4'hF, 2'b00, off[17:0]};
        return low;
    endfunction

    assign hit = !cpu_as_n && (!cpu_uds_n || !cpu_lds_n) && (cpu_addr[23:20] == CPU_WIN);
    assign dbg_state = state;

    // Handshake: a slot transaction is offered while slot_select=1 and completes on
    // the first sampled slot_ack_n=0; the CPU strobe is answered by DTACK/BERR held
    // low until AS is seen high, and the bus is only reused once both AS and ack are idle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            slot_select   <= 1'b0;
            cpu_dtack_n   <= 1'b1;
            cpu_berr_n    <= 1'b1;
            cpu_data_out  <= 16'h0;
            slot_addr     <= 32'h0;
            slot_data_out <= 16'h0;
            slot_uds_lds  <= 2'b00;
            slot_rw_n     <= 1'b1;
            wait_cnt      <= 8'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hit) begin
                        slot_addr     <= {4'hF, SLOT_ID, remap_offset(cpu_addr[19:0])};
                        slot_rw_n     <= cpu_rw_n;
                        slot_uds_lds  <= {~cpu_uds_n, ~cpu_lds_n};
                        slot_data_out <= cpu_data_in;
                        slot_select   <= 1'b1;
                        wait_cnt      <= 8'h0;
                        state         <= S_REQ;
                    end else begin
                        slot_select   <= 1'b0;
                        cpu_dtack_n   <= 1'b1;
                        cpu_berr_n    <= 1'b1;
                        cpu_data_out  <= 16'h0;
                        slot_addr     <= 32'h0;
                        slot_data_out <= 16'h0;
                        slot_uds_lds  <= 2'b00;
                        slot_rw_n     <= 1'b1;
                        wait_cnt      <= 8'h0;
                    end
                end
                S_REQ: begin
                    // An abort beats a simultaneous ack: the CPU has already left the cycle.
                    if (cpu_as_n) begin
                        slot_select <= 1'b0;
                        state       <= S_RELEASE;
                    end else if (!slot_ack_n) begin
                        slot_select <= 1'b0;
                        if (slot_rw_n)
                            cpu_data_out <= slot_data_in;
                        cpu_dtack_n <= 1'b0;
                        state       <= S_HOLD;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        slot_select <= 1'b0;
                        cpu_berr_n  <= 1'b0;
                        state       <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (cpu_as_n) begin
                        cpu_dtack_n <= 1'b1;
                        state       <= S_RELEASE;
                    end
                end
                S_ERR: begin
                    if (cpu_as_n) begin
                        cpu_berr_n <= 1'b1;
                        state      <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (slot_ack_n && cpu_as_n) begin
                        cpu_data_out  <= 16'h0;
                        slot_addr     <= 32'h0;
                        slot_data_out <= 16'h0;
                        slot_uds_lds  <= 2'b00;
                        slot_rw_n     <= 1'b1;
                        wait_cnt      <= 8'h0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nubus_slot_bridge.sv
// Directed bench for nubus_slot_bridge: transaction tasks predict the outputs after
// every edge into a scoreboard, with a few literal pins on key addresses and timings.
module tb_nubus_slot_bridge;

    localparam int W = 70;
    localparam logic [3:0] SLOT_ID = 4'h9;
    localparam logic [3:0] CPU_WIN = 4'h6;
    localparam int TIMEOUT = 255;

    logic        clk;
    logic        reset_n;
    logic [23:0] cpu_addr;
    logic        cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw_n;
    logic [15:0] cpu_data_in;
    logic [15:0] cpu_data_out;
    logic        cpu_dtack_n, cpu_berr_n;
    logic [31:0] slot_addr;
    logic [15:0] slot_data_out;
    logic [1:0]  slot_uds_lds;
    logic        slot_rw_n, slot_select;
    logic        slot_ack_n;
    logic [15:0] slot_data_in;
    logic [2:0]  dbg_state;

    nubus_slot_bridge #(.SLOT_ID(SLOT_ID), .CPU_WIN(CPU_WIN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_as_n(cpu_as_n), .cpu_uds_n(cpu_uds_n),
        .cpu_lds_n(cpu_lds_n), .cpu_rw_n(cpu_rw_n), .cpu_data_in(cpu_data_in),
        .cpu_data_out(cpu_data_out), .cpu_dtack_n(cpu_dtack_n), .cpu_berr_n(cpu_berr_n),
        .slot_addr(slot_addr), .slot_data_out(slot_data_out), .slot_uds_lds(slot_uds_lds),
        .slot_rw_n(slot_rw_n), .slot_select(slot_select), .slot_ack_n(slot_ack_n),
        .slot_data_in(slot_data_in), .dbg_state(dbg_state)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           en;
        logic [W-1:0] mask;
        logic [W-1:0] val;
    } pin_t;

    logic [W-1:0] exp_q[$];
    pin_t         pin_q[$];
    string        name_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    // expected outputs after the next edge
    logic [15:0] e_dout;
    logic        e_dtack, e_berr;
    logic [31:0] e_saddr;
    logic [15:0] e_sdata;
    logic [1:0]  e_ul;
    logic        e_rw, e_sel;
    string       cur_name;
    pin_t        cur_pin;

    function automatic logic [31:0] model_addr(input logic [23:0] addr);
        int unsigned off;
        int unsigned low;
        off = int'(addr) % 32'h100000;
        if (off < 32'h80000)      low = off;
        else if (off < 32'hC0000) low = 32'h080000 + (off % 32'h10000);
        else                      low = 32'hF00000 + (off % 32'h40000);
        return 32'hF000_0000 + (32'(SLOT_ID) << 24) + low;
    endfunction

    function automatic logic [W-1:0] exp_vec();
        return {e_dout, e_dtack, e_berr, e_saddr, e_sdata, e_ul, e_rw, e_sel};
    endfunction

    task automatic set_idle();
        e_dout = 16'h0; e_dtack = 1'b1; e_berr = 1'b1; e_saddr = 32'h0;
        e_sdata = 16'h0; e_ul = 2'b00; e_rw = 1'b1; e_sel = 1'b0;
    endtask

    task automatic pin(input logic [W-1:0] mask, input logic [W-1:0] val);
        cur_pin.en = 1'b1; cur_pin.mask = mask; cur_pin.val = val;
    endtask
    task automatic pin_saddr(input logic [31:0] v); pin(W'(32'hFFFF_FFFF) << 20, W'(v) << 20); endtask
    task automatic pin_sel(input logic b);          pin(W'(1), W'(b));                           endtask
    task automatic pin_berr(input logic b);         pin(W'(1) << 52, W'(b) << 52);               endtask
    task automatic pin_dout(input logic [15:0] v);  pin(W'(16'hFFFF) << 54, W'(v) << 54);        endtask

    // one clock: queue the prediction, let the edge happen, return just after it
    task automatic step();
        exp_q.push_back(exp_vec());
        pin_q.push_back(cur_pin);
        name_q.push_back(cur_name);
        cur_pin.en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic drive_cpu(input logic [23:0] addr, input logic uds_n, input logic lds_n,
                             input logic rw_n, input logic [15:0] wdata, input logic as_n);
        cpu_addr = addr; cpu_uds_n = uds_n; cpu_lds_n = lds_n;
        cpu_rw_n = rw_n; cpu_data_in = wdata; cpu_as_n = as_n;
    endtask

    task automatic do_hit(input logic [23:0] addr, input logic uds_n, input logic lds_n,
                          input logic rw_n, input logic [15:0] wdata);
        drive_cpu(addr, uds_n, lds_n, rw_n, wdata, 1'b0);
        slot_ack_n = 1'b1;
        e_sel = 1'b1; e_saddr = model_addr(addr); e_ul = {~uds_n, ~lds_n};
        e_rw = rw_n; e_sdata = wdata;
        step();
    endtask

    task automatic wait_req(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_ack(input logic [15:0] rdata);
        slot_ack_n = 1'b0; slot_data_in = rdata;
        e_sel = 1'b0; e_dtack = 1'b0;
        if (e_rw) e_dout = rdata;
        step();
    endtask

    // CPU holds AS two cycles, lifts AS while ack still low, then ack lifts
    task automatic end_cycle();
        step();
        step();
        cpu_as_n = 1'b1; e_dtack = 1'b1; e_berr = 1'b1;
        step();
        step();
        slot_ack_n = 1'b1; set_idle();
        step();
        step();
    endtask

    task automatic word_txn(input string nm, input logic [23:0] addr, input logic uds_n,
                            input logic lds_n, input logic rw_n, input logic [15:0] wdata,
                            input int waits, input logic [15:0] rdata);
        cur_name = nm;
        do_hit(addr, uds_n, lds_n, rw_n, wdata);
        wait_req(waits);
        do_ack(rdata);
        end_cycle();
    endtask

    // scoreboard compare
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] exp_v;
            logic [W-1:0] act_v;
            pin_t         p;
            string        nm;
            exp_v = exp_q.pop_front();
            p     = pin_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {cpu_data_out, cpu_dtack_n, cpu_berr_n, slot_addr, slot_data_out,
                     slot_uds_lds, slot_rw_n, slot_select};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL %s outputs: got %h want %h (dout,dtack,berr,saddr,sdata,ul,rw,sel)",
                         nm, act_v, exp_v);
            end
            if (p.en) begin
                n_cmp++;
                if ((act_v & p.mask) !== (p.val & p.mask)) begin
                    n_err++;
                    $display("FAIL %s literal: got %h want %h", nm, act_v & p.mask, p.val & p.mask);
                end
            end
        end
    end

    initial begin
        cur_pin.en = 1'b0; cur_pin.mask = '0; cur_pin.val = '0;
        reset_n = 1'b0;
        drive_cpu(24'h0, 1'b1, 1'b1, 1'b1, 16'h0, 1'b1);
        slot_ack_n = 1'b1; slot_data_in = 16'h0;
        set_idle();

        cur_name = "reset";
        pin_saddr(32'h0);
        step();
        step();
        reset_n = 1'b1;

        cur_name = "nonhit_window";
        drive_cpu(24'h500010, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
        pin_sel(1'b0);
        step();
        cur_name = "nonhit_nostrobe";
        drive_cpu(24'h600010, 1'b1, 1'b1, 1'b1, 16'h0, 1'b0);
        step();
        cur_name = "nonhit_as";
        drive_cpu(24'h600010, 1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
        step();

        // word read, ack after one wait cycle
        cur_name = "read_600010";
        pin_saddr(32'hF900_0010);
        do_hit(24'h600010, 1'b0, 1'b0, 1'b1, 16'h0);
        wait_req(1);
        pin_dout(16'hBEEF);
        do_ack(16'hBEEF);
        end_cycle();

        // upper-byte write, immediate ack; slot read data must not reach the CPU
        cur_name = "write_680000";
        pin_saddr(32'hF908_0000);
        do_hit(24'h680000, 1'b0, 1'b1, 1'b0, 16'hA500);
        do_ack(16'h1234);
        end_cycle();

        cur_name = "rom_6C0004";
        pin_saddr(32'hF9F0_0004);
        do_hit(24'h6C0004, 1'b0, 1'b0, 1'b1, 16'h0);
        wait_req(2);
        do_ack(16'h5A5A);
        end_cycle();

        word_txn("edge_67FFFE", 24'h67FFFE, 1'b1, 1'b0, 1'b1, 16'h0, 0, 16'h00C3);
        word_txn("edge_6BFFFE", 24'h6BFFFE, 1'b0, 1'b0, 1'b0, 16'h7E81, 3, 16'hFFFF);
        word_txn("edge_6FFFFE", 24'h6FFFFE, 1'b0, 1'b0, 1'b1, 16'h0, 1, 16'h8001);

        // timeout: berr exactly TIMEOUT+1 edges after select rises
        cur_name = "timeout";
        pin_sel(1'b1);
        do_hit(24'h600100, 1'b0, 1'b0, 1'b1, 16'h0);
        for (int i = 0; i < TIMEOUT; i++) begin
            if (i == TIMEOUT - 1) pin_berr(1'b1);
            step();
        end
        e_sel = 1'b0; e_berr = 1'b0;
        pin_berr(1'b0);
        step();
        step();
        step();
        cpu_as_n = 1'b1; e_berr = 1'b1;
        step();
        set_idle();
        step();
        step();

        // abort on its own
        cur_name = "abort";
        do_hit(24'h600040, 1'b0, 1'b0, 1'b1, 16'h0);
        wait_req(1);
        cpu_as_n = 1'b1; e_sel = 1'b0;
        step();
        set_idle();
        step();
        step();

        // abort together with ack, then a new hit attempt while ack is still low
        cur_name = "abort_ack";
        do_hit(24'h600080, 1'b0, 1'b0, 1'b1, 16'h0);
        wait_req(1);
        cpu_as_n = 1'b1; slot_ack_n = 1'b0; slot_data_in = 16'hDEAD;
        e_sel = 1'b0;
        pin_dout(16'h0);
        step();
        drive_cpu(24'h600080, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
        pin_sel(1'b0);
        step();
        step();
        cpu_as_n = 1'b1;
        step();
        slot_ack_n = 1'b1; set_idle();
        step();
        step();

        // reset while holding dtack
        cur_name = "reset_in_hold";
        do_hit(24'h600200, 1'b0, 1'b0, 1'b1, 16'h0);
        do_ack(16'h1111);
        step();
        reset_n = 1'b0; set_idle();
        pin_saddr(32'h0);
        step();
        reset_n = 1'b1; cpu_as_n = 1'b1; slot_ack_n = 1'b1;
        step();
        word_txn("after_reset", 24'h600020, 1'b0, 1'b0, 1'b1, 16'h0, 2, 16'h2468);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
